pu_vector_window_gen: RTL and testbench

- Vector generator between the processing-unit input buffer (a FIFO of NUM_PE-word vectors) and the PE array.
- Holds the current NUM_PE-word image vector plus the next vector, and presents the current vector on NUM_PE lanes.
- Presents one extra serial lane fed from the next vector, so PEs see a sliding kernel window horizontally.
- Sequenced by the PU controller through POP / SHIFT / NEXTROW commands.

---
 rtl/pu_pkg.sv | 45 ++++
 rtl/pu_vecgen_fetch.sv | 62 ++++++
 rtl/pu_vector_window_gen.sv | 109 ++++++++++
 tb/tb_pu_vector_window_gen.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pu_pkg.sv
// ----------------------------------------------------------------------------
// pu_pkg
// Shared definitions for the processing-unit vector window generator:
//   - default pixel width and PE lane count
//   - decoded command encoding, with the NEXTROW > POP > SHIFT priority
//   - lane pointer helper (saturating advance across the PE lanes)
// ----------------------------------------------------------------------------
package pu_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned NUM_PE_DEF     = 4;

    // Decoded controller command. CMD_REWIND is POP and SHIFT together.
    typedef enum logic [2:0] {
        CMD_IDLE,
        CMD_SHIFT,
        CMD_REWIND,
        CMD_POP,
        CMD_NEXTROW
    } vg_cmd_e;

    // Commands only take effect while the generator is ready.
    function automatic vg_cmd_e decode_cmd(input logic ready,
                                           input logic nextrow,
                                           input logic pop,
                                           input logic shift);
        vg_cmd_e cmd;
        cmd = CMD_IDLE;
        if (ready) begin
            if (nextrow)          cmd = CMD_NEXTROW;
            else if (pop && shift) cmd = CMD_REWIND;
            else if (pop)          cmd = CMD_POP;
            else if (shift)        cmd = CMD_SHIFT;
        end
        return cmd;
    endfunction

    // Next serial lane index; holds at the last lane so further shifts
    // re-present the final word of the next vector.
    function automatic int unsigned next_lane(input int unsigned lane,
                                              input int unsigned num_pe);
        return (lane + 1 < num_pe) ? lane + 1 : num_pe - 1;
    endfunction

endpackage

// File: rtl/pu_vecgen_fetch.sv
// ----------------------------------------------------------------------------
// pu_vecgen_fetch
// Fetch / valid tracker for the vector window generator. Issues FIFO reads
// while a vector slot is free, keeps at most one read in flight, and tells
// the datapath which slot the returning word fills.
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   inbuf_empty_i   input FIFO empty
//   clr_all_i       accepted NEXTROW: invalidate both slots
//   clr_nxt_i       accepted POP: next slot moved to current, refill next
//   inbuf_pop_o     FIFO read request (combinational, held low in reset)
//   fill_cur_o      returning word is written to the current slot
//   fill_nxt_o      returning word is written to the next slot
//   ready_o         both slots valid and no read in flight
// ----------------------------------------------------------------------------
module pu_vecgen_fetch (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inbuf_empty_i,
    input  logic clr_all_i,
    input  logic clr_nxt_i,
    output logic inbuf_pop_o,
    output logic fill_cur_o,
    output logic fill_nxt_o,
    output logic ready_o
);

    logic cur_v_q, cur_v_d;
    logic nxt_v_q, nxt_v_d;
    logic rd_pend_q, rd_pend_d;

    always_comb begin
        inbuf_pop_o = rst_ni && !inbuf_empty_i && !rd_pend_q
                      && !(cur_v_q && nxt_v_q);
        ready_o     = cur_v_q && nxt_v_q && !rd_pend_q;

        cur_v_d = clr_all_i ? 1'b0 : cur_v_q;
        nxt_v_d = (clr_all_i || clr_nxt_i) ? 1'b0 : nxt_v_q;

        // Target is chosen after the command's clears, so a word landing
        // on the same edge as a NEXTROW goes to the (now empty) current slot.
        fill_cur_o = rd_pend_q && !cur_v_d;
        fill_nxt_o = rd_pend_q && cur_v_d;
        if (fill_cur_o) cur_v_d = 1'b1;
        if (fill_nxt_o) nxt_v_d = 1'b1;

        // FIFO data is valid the cycle after the read request.
        rd_pend_d = inbuf_pop_o;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cur_v_q   <= 1'b0;
            nxt_v_q   <= 1'b0;
            rd_pend_q <= 1'b0;
        end else begin
            cur_v_q   <= cur_v_d;
            nxt_v_q   <= nxt_v_d;
            rd_pend_q <= rd_pend_d;
        end
    end

endmodule

// File: rtl/pu_vector_window_gen.sv
// ----------------------------------------------------------------------------
// pu_vector_window_gen
// Holds the current and next NUM_PE-word image vectors from the PU input
// buffer and drives the PE array: lanes 0..NUM_PE-1 carry the current
// vector, lane NUM_PE carries a serial word taken from the next vector so
// the PEs see a horizontally sliding kernel window.
//   CLK                 clock
//   RESET               asynchronous active-low reset
//   VECTORGEN_POP       advance to the next horizontal stage
//   VECTORGEN_SHIFT     shift the next serial word into the extra lane
//   VECTORGEN_NEXTROW   drop held vectors, start a new image row
//   VECTORGEN_DATA_IN   FIFO read data, valid the cycle after INBUF_POP
//   INBUF_EMPTY         input FIFO empty
//   INBUF_POP           FIFO read request
//   VECTORGEN_DATA_OUT  {extra lane, current vector}, lane p at p*DATA_WIDTH
//   VECTORGEN_READY     both vectors valid; commands accepted
// ----------------------------------------------------------------------------
module pu_vector_window_gen
    import pu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned NUM_PE     = NUM_PE_DEF
) (
    input  logic                             CLK,
    input  logic                             RESET,
    input  logic                             VECTORGEN_POP,
    input  logic                             VECTORGEN_SHIFT,
    input  logic                             VECTORGEN_NEXTROW,
    input  logic [NUM_PE*DATA_WIDTH-1:0]     VECTORGEN_DATA_IN,
    input  logic                             INBUF_EMPTY,
    output logic                             INBUF_POP,
    output logic [(NUM_PE+1)*DATA_WIDTH-1:0] VECTORGEN_DATA_OUT,
    output logic                             VECTORGEN_READY
);

    localparam int unsigned PW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    logic [NUM_PE-1:0][DATA_WIDTH-1:0] cur_vec_q, cur_vec_d;
    logic [NUM_PE-1:0][DATA_WIDTH-1:0] nxt_vec_q, nxt_vec_d;
    logic [DATA_WIDTH-1:0]             extra_q, extra_d;
    logic [PW-1:0]                     shift_ptr_q, shift_ptr_d;

    vg_cmd_e cmd;
    logic    ready;
    logic    fill_cur;
    logic    fill_nxt;

    assign cmd = decode_cmd(ready, VECTORGEN_NEXTROW, VECTORGEN_POP,
                            VECTORGEN_SHIFT);

    pu_vecgen_fetch u_fetch (
        .clk_i         (CLK),
        .rst_ni        (RESET),
        .inbuf_empty_i (INBUF_EMPTY),
        .clr_all_i     (cmd == CMD_NEXTROW),
        .clr_nxt_i     (cmd == CMD_POP),
        .inbuf_pop_o   (INBUF_POP),
        .fill_cur_o    (fill_cur),
        .fill_nxt_o    (fill_nxt),
        .ready_o       (ready)
    );

    always_comb begin
        cur_vec_d   = cur_vec_q;
        nxt_vec_d   = nxt_vec_q;
        extra_d     = extra_q;
        shift_ptr_d = shift_ptr_q;

        unique case (cmd)
            CMD_NEXTROW, CMD_REWIND: begin
                extra_d     = '0;
                shift_ptr_d = '0;
            end
            CMD_POP: begin
                cur_vec_d   = nxt_vec_q;
                extra_d     = '0;
                shift_ptr_d = '0;
            end
            CMD_SHIFT: begin
                extra_d     = nxt_vec_q[shift_ptr_q];
                shift_ptr_d = PW'(next_lane(32'(shift_ptr_q), NUM_PE));
            end
            default: ;
        endcase

        // A capture never coincides with an accepted command (ready
        // requires no read in flight), so the order here is immaterial.
        if (fill_cur) cur_vec_d = VECTORGEN_DATA_IN;
        if (fill_nxt) nxt_vec_d = VECTORGEN_DATA_IN;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cur_vec_q   <= '0;
            nxt_vec_q   <= '0;
            extra_q     <= '0;
            shift_ptr_q <= '0;
        end else begin
            cur_vec_q   <= cur_vec_d;
            nxt_vec_q   <= nxt_vec_d;
            extra_q     <= extra_d;
            shift_ptr_q <= shift_ptr_d;
        end
    end

    assign VECTORGEN_DATA_OUT = {extra_q, cur_vec_q};
    assign VECTORGEN_READY    = ready;

endmodule

// File: tb/tb_pu_vector_window_gen.sv
module tb_pu_vector_window_gen;

    localparam int unsigned DW  = 8;
    localparam int unsigned NPE = 4;
    localparam int unsigned VW  = NPE * DW;
    localparam int unsigned OW  = (NPE + 1) * DW;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          VECTORGEN_POP = 1'b0;
    logic          VECTORGEN_SHIFT = 1'b0;
    logic          VECTORGEN_NEXTROW = 1'b0;
    logic [VW-1:0] VECTORGEN_DATA_IN = '0;
    logic          INBUF_EMPTY;
    logic          INBUF_POP;
    logic [OW-1:0] VECTORGEN_DATA_OUT;
    logic          VECTORGEN_READY;

    pu_vector_window_gen #(.DATA_WIDTH(DW), .NUM_PE(NPE)) dut (
        .CLK                (CLK),
        .RESET              (RESET),
        .VECTORGEN_POP      (VECTORGEN_POP),
        .VECTORGEN_SHIFT    (VECTORGEN_SHIFT),
        .VECTORGEN_NEXTROW  (VECTORGEN_NEXTROW),
        .VECTORGEN_DATA_IN  (VECTORGEN_DATA_IN),
        .INBUF_EMPTY        (INBUF_EMPTY),
        .INBUF_POP          (INBUF_POP),
        .VECTORGEN_DATA_OUT (VECTORGEN_DATA_OUT),
        .VECTORGEN_READY    (VECTORGEN_READY)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- input FIFO model (registered read data) ----------------
    logic [VW-1:0] mem [0:31];
    int            rd_ptr = 0;
    int            wr_ptr = 0;
    int            pops = 0;
    logic          force_empty = 1'b0;

    assign INBUF_EMPTY = force_empty || (rd_ptr == wr_ptr);

    always @(posedge CLK) begin
        if (INBUF_POP && rd_ptr != wr_ptr) begin
            VECTORGEN_DATA_IN <= mem[rd_ptr];
            rd_ptr            <= rd_ptr + 1;
            pops              <= pops + 1;
        end
    end

    // ---------------- behavioural model ----------------
    // held: vectors currently owned by the generator, oldest first.
    logic [VW-1:0] held [$];
    logic [VW-1:0] shown = '0;
    logic [VW-1:0] tmp;
    logic [DW-1:0] m_extra = '0;
    int            sidx = 0;
    bit            pend = 0;
    bit            m_rdy, m_want;
    bit            chk_en = 0;

    initial begin
        forever begin
            @(posedge CLK or negedge RESET);
            if (!RESET) begin
                held.delete();
                shown = '0; m_extra = '0; sidx = 0; pend = 0;
            end else begin
                m_rdy  = (held.size() == 2) && !pend;
                m_want = !INBUF_EMPTY && !pend && (held.size() < 2);
                if (m_rdy) begin
                    if (VECTORGEN_NEXTROW) begin
                        held.delete(); m_extra = '0; sidx = 0;
                    end else if (VECTORGEN_POP && VECTORGEN_SHIFT) begin
                        m_extra = '0; sidx = 0;
                    end else if (VECTORGEN_POP) begin
                        void'(held.pop_front());
                        shown = held[0]; m_extra = '0; sidx = 0;
                    end else if (VECTORGEN_SHIFT) begin
                        tmp = held[1];
                        m_extra = tmp[sidx*DW +: DW];
                        if (sidx < NPE - 1) sidx++;
                    end
                end
                if (pend) begin
                    if (held.size() == 0) shown = VECTORGEN_DATA_IN;
                    held.push_back(VECTORGEN_DATA_IN);
                end
                pend = m_want;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge CLK);
            if (chk_en) begin
                chk("data_out", 64'(VECTORGEN_DATA_OUT), 64'({m_extra, shown}));
                chk("ready", 64'(VECTORGEN_READY),
                    64'((held.size() == 2) && !pend));
                chk("inbuf_pop", 64'(INBUF_POP),
                    64'(RESET && !INBUF_EMPTY && !pend && (held.size() < 2)));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic do_cmd(input logic p, input logic s, input logic n);
        VECTORGEN_POP = p; VECTORGEN_SHIFT = s; VECTORGEN_NEXTROW = n;
        @(posedge CLK); #1;
        VECTORGEN_POP = 1'b0; VECTORGEN_SHIFT = 1'b0; VECTORGEN_NEXTROW = 1'b0;
    endtask

    task automatic wait_ready(input string nm, output int cyc);
        cyc = 0;
        while (!VECTORGEN_READY && cyc < 60) begin
            @(posedge CLK); #1; cyc++;
        end
        chk(nm, 64'(VECTORGEN_READY), 64'd1);
    endtask

    task automatic shift_expect(input string nm, input logic [63:0] exp);
        do_cmd(1'b0, 1'b1, 1'b0);
        chk(nm, 64'(VECTORGEN_DATA_OUT), exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int cyc;
        int p0;
        logic [VW-1:0] words [0:8];
        words = '{32'h04030201, 32'h08070605, 32'h00000a09,
                  32'h0e0d0c0b, 32'h1211100f, 32'h00001413,
                  32'h18171615, 32'h1c1b1a19, 32'h00001e1d};
        for (int i = 0; i < 9; i++) mem[i] = words[i];
        wr_ptr = 9;

        RESET = 1'b1;
        #1 RESET = 1'b0;
        step(3);
        chk_en = 1;
        chk("rst_data_out", 64'(VECTORGEN_DATA_OUT), 64'd0);
        chk("rst_ready", 64'(VECTORGEN_READY), 64'd0);
        chk("rst_pop", 64'(INBUF_POP), 64'd0);

        RESET = 1'b1;
        wait_ready("initial_ready", cyc);
        chk("initial_out", 64'(VECTORGEN_DATA_OUT), 64'h0004030201);
        chk("initial_pops", 64'(pops), 64'd2);

        shift_expect("shift1", 64'h0504030201);
        shift_expect("shift2", 64'h0604030201);
        shift_expect("shift3", 64'h0704030201);
        shift_expect("shift4", 64'h0804030201);
        shift_expect("shift5_sat", 64'h0804030201);

        p0 = pops;
        do_cmd(1'b1, 1'b1, 1'b0);
        chk("rewind_out", 64'(VECTORGEN_DATA_OUT), 64'h0004030201);
        step(3);
        chk("rewind_no_fetch", 64'(pops), 64'(p0));
        chk("rewind_ready", 64'(VECTORGEN_READY), 64'd1);

        do_cmd(1'b1, 1'b0, 1'b0);
        chk("pop_ready_low", 64'(VECTORGEN_READY), 64'd0);
        wait_ready("pop_ready", cyc);
        chk("pop_gap_ge2", 64'(cyc >= 2), 64'd1);
        chk("pop_one_fetch", 64'(pops), 64'(p0 + 1));
        chk("pop_out", 64'(VECTORGEN_DATA_OUT), 64'h0008070605);
        shift_expect("s1_shift1", 64'h0908070605);
        shift_expect("s1_shift2", 64'h0a08070605);

        do_cmd(1'b0, 1'b0, 1'b1);
        wait_ready("nextrow_ready", cyc);
        chk("nextrow_out", 64'(VECTORGEN_DATA_OUT), 64'h000e0d0c0b);
        shift_expect("row1_shift", 64'h0f0e0d0c0b);

        force_empty = 1'b1;
        do_cmd(1'b1, 1'b0, 1'b0);
        step(4);
        chk("empty_pop", 64'(INBUF_POP), 64'd0);
        chk("empty_ready", 64'(VECTORGEN_READY), 64'd0);
        do_cmd(1'b0, 1'b1, 1'b0);
        chk("empty_cmd_ignored", 64'(VECTORGEN_DATA_OUT), 64'h001211100f);
        force_empty = 1'b0;
        wait_ready("refill_ready", cyc);
        chk("refill_out", 64'(VECTORGEN_DATA_OUT), 64'h001211100f);
        shift_expect("refill_shift", 64'h131211100f);

        do_cmd(1'b1, 1'b0, 1'b0);
        chk("pre_rst_out", 64'(VECTORGEN_DATA_OUT), 64'h0000001413);
        chk("pre_rst_pop", 64'(INBUF_POP), 64'd1);
        @(posedge CLK); #2;
        RESET = 1'b0;
        #1;
        chk("midrst_out", 64'(VECTORGEN_DATA_OUT), 64'd0);
        chk("midrst_ready", 64'(VECTORGEN_READY), 64'd0);
        chk("midrst_pop", 64'(INBUF_POP), 64'd0);
        step(2);
        RESET = 1'b1;
        wait_ready("restart_ready", cyc);
        chk("restart_out", 64'(VECTORGEN_DATA_OUT), 64'h001c1b1a19);
        shift_expect("restart_shift", 64'h1d1c1b1a19);

        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
